// File: rtl/dual_port_ram_cfg.sv
// True dual-port synchronous RAM with a post-reset clear sequencer, collision arbitration and counting.
// Read latency 1+OUT_REG cycles; no backpressure, an access is accepted whenever its port enable is high in READY.
// Port accesses are ignored while the clear sequencer runs (init_busy high).
module dual_port_ram_cfg #(
    parameter int DATA_W   = 9,
    parameter int ADDR_W   = 4,
    parameter int WIN_B    = 0,
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 0,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    input  logic              en_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] din_b,
    output logic [DATA_W-1:0] dout_a,
    output logic              dvalid_a,
    output logic [DATA_W-1:0] dout_b,
    output logic              dvalid_b,
    output logic              collision_detected,
    output logic [CNT_W-1:0]  collision_count,
    output logic              init_busy
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nxt;
    logic              clr_we;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              ready;
    logic              acc_a;
    logic              acc_b;
    logic              wr_a;
    logic              wr_b;
    logic              collision;
    logic              wr_a_eff;
    logic              wr_b_eff;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    logic [DATA_W-1:0] d1_a;
    logic [DATA_W-1:0] d1_b;
    logic              v1_a;
    logic              v1_b;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_INIT;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        clr_we    = 1'b0;
        case (state)
            ST_INIT: begin
                clr_we  = 1'b1;
                ptr_nxt = ptr + 1'b1;
                if (ptr == ADDR_W'(DEPTH - 1)) begin
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                state_nxt = ST_READY;
            end
            default: begin
                state_nxt = ST_INIT;
                ptr_nxt   = '0;
            end
        endcase
    end

    assign ready     = (state == ST_READY);
    assign init_busy = ~ready;

    // ------------------------------------------------------------------
    // Access qualification and collision arbitration
    // ------------------------------------------------------------------
    assign acc_a     = ready & en_a;
    assign acc_b     = ready & en_b;
    assign wr_a      = acc_a & we_a;
    assign wr_b      = acc_b & we_b;
    assign collision = wr_a & wr_b & (addr_a == addr_b);

    // On a same-address collision the losing port's write is dropped.
    assign wr_a_eff  = wr_a & ~(collision & (WIN_B != 0));
    assign wr_b_eff  = wr_b & ~(collision & (WIN_B == 0));

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (clr_we) begin
                mem[ptr] <= '0;
            end else begin
                if (wr_a_eff) begin
                    mem[addr_a] <= din_a;
                end
                if (wr_b_eff) begin
                    mem[addr_b] <= din_b;
                end
            end
        end
    end

    // Write-first forwards whatever actually lands in the array this cycle.
    always_comb begin
        rd_a = mem[addr_a];
        rd_b = mem[addr_b];
        if (RDW_MODE != 0) begin
            if (wr_b_eff && (addr_b == addr_a)) begin
                rd_a = din_b;
            end else if (wr_a_eff) begin
                rd_a = din_a;
            end
            if (wr_a_eff && (addr_a == addr_b)) begin
                rd_b = din_a;
            end else if (wr_b_eff) begin
                rd_b = din_b;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d1_a <= '0;
            d1_b <= '0;
            v1_a <= 1'b0;
            v1_b <= 1'b0;
        end else begin
            v1_a <= acc_a;
            v1_b <= acc_b;
            if (acc_a) begin
                d1_a <= rd_a;
            end
            if (acc_b) begin
                d1_b <= rd_b;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] d2_a;
            logic [DATA_W-1:0] d2_b;
            logic              v2_a;
            logic              v2_b;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    d2_a <= '0;
                    d2_b <= '0;
                    v2_a <= 1'b0;
                    v2_b <= 1'b0;
                end else begin
                    v2_a <= v1_a;
                    v2_b <= v1_b;
                    if (v1_a) begin
                        d2_a <= d1_a;
                    end
                    if (v1_b) begin
                        d2_b <= d1_b;
                    end
                end
            end

            assign dout_a   = d2_a;
            assign dout_b   = d2_b;
            assign dvalid_a = v2_a;
            assign dvalid_b = v2_b;
        end else begin : g_no_out_reg
            assign dout_a   = d1_a;
            assign dout_b   = d1_b;
            assign dvalid_a = v1_a;
            assign dvalid_b = v1_b;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Collision reporting; counter sticks at all-ones
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            collision_detected <= 1'b0;
            collision_count    <= '0;
        end else begin
            collision_detected <= collision;
            if (collision && (collision_count != {CNT_W{1'b1}})) begin
                collision_count <= collision_count + 1'b1;
            end
        end
    end

endmodule
